// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: Q2.14 format, constants and complex sample type.
package fft_pkg;

    localparam int unsigned DW   = 16;
    localparam int unsigned FRAC = 14;

    localparam logic [DW-1:0] ONE     = 16'h4000;
    localparam logic [DW-1:0] NEG_ONE = 16'hC000;
    localparam logic [DW-1:0] MAX     = 16'h7FFF;
    localparam logic [DW-1:0] MIN     = 16'h8000;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } cplx_t;

endpackage

// File: rtl/cmul_q14.sv
// Two-stage registered complex multiply t = B*W with round-half-up renormalisation.
module cmul_q14 #(
    parameter int unsigned DW   = fft_pkg::DW,
    parameter int unsigned FRAC = fft_pkg::FRAC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en1,
    input  logic                 en2,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    input  logic signed [DW-1:0] w_re,
    input  logic signed [DW-1:0] w_im,
    output logic signed [DW+1:0] t_re,
    output logic signed [DW+1:0] t_im
);
    import fft_pkg::*;

    localparam int unsigned PW = 2 * DW + 1;
    localparam logic signed [PW-1:0] RND = PW'(1) <<< (FRAC - 1);

    logic signed [2*DW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
    logic signed [PW-1:0]   sum_re, sum_im;
    logic signed [DW+1:0]   t_re_q, t_im_q;

    always_comb begin
        sum_re = PW'(p_rr_q) - PW'(p_ii_q);
        sum_im = PW'(p_ri_q) + PW'(p_ir_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_rr_q <= '0;
            p_ii_q <= '0;
            p_ri_q <= '0;
            p_ir_q <= '0;
            t_re_q <= '0;
            t_im_q <= '0;
        end else begin
            if (en1) begin
                p_rr_q <= (2*DW)'(b_re) * (2*DW)'(w_re);
                p_ii_q <= (2*DW)'(b_im) * (2*DW)'(w_im);
                p_ri_q <= (2*DW)'(b_re) * (2*DW)'(w_im);
                p_ir_q <= (2*DW)'(b_im) * (2*DW)'(w_re);
            end
            // Keeping only DW+2 bits after the shift is intentional wrap, not saturation.
            if (en2) begin
                t_re_q <= (DW+2)'((sum_re + RND) >>> FRAC);
                t_im_q <= (DW+2)'((sum_im + RND) >>> FRAC);
            end
        end
    end

    assign t_re = t_re_q;
    assign t_im = t_im_q;

endmodule

// File: rtl/butterfly_pipe.sv
// Three-stage radix-2 DIT butterfly X = A + B*W, Y = A - B*W with optional 1/2 scaling,
// saturation, sticky overflow and valid/ready flow control on both sides.
module butterfly_pipe #(
    parameter int unsigned DW   = fft_pkg::DW,
    parameter int unsigned FRAC = fft_pkg::FRAC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    input  logic signed [DW-1:0] w_re,
    input  logic signed [DW-1:0] w_im,
    input  logic                 scale,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] x_re,
    output logic signed [DW-1:0] x_im,
    output logic signed [DW-1:0] y_re,
    output logic signed [DW-1:0] y_im,
    output logic                 ovf,
    input  logic                 clr
);
    import fft_pkg::*;

    localparam int unsigned SW = DW + 3;
    localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (DW - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

    logic v1_q, v2_q, v3_q, ovf_q;
    logic ld1, ld2, ld3;
    logic signed [DW-1:0] a1_re_q, a1_im_q, a2_re_q, a2_im_q;
    logic s1_q, s2_q;
    logic signed [DW+1:0] t_re, t_im;
    logic signed [DW-1:0] x_re_q, x_im_q, y_re_q, y_im_q;
    logic signed [SW-1:0] xr, xi, yr, yi;
    logic [DW:0] sxr, sxi, syr, syi;
    logic sat_any;

    // Load chain ripples back from the consumer; no in_valid term, so no valid->ready path.
    assign ld3      = !v3_q || out_ready;
    assign ld2      = !v2_q || ld3;
    assign ld1      = !v1_q || ld2;
    assign in_ready = ld1;

    cmul_q14 #(
        .DW   (DW),
        .FRAC (FRAC)
    ) u_cmul (
        .clk   (clk),
        .rst_n (rst_n),
        .en1   (ld1),
        .en2   (ld2),
        .b_re  (b_re),
        .b_im  (b_im),
        .w_re  (w_re),
        .w_im  (w_im),
        .t_re  (t_re),
        .t_im  (t_im)
    );

    function automatic logic [DW:0] sat_fn(input logic signed [SW-1:0] v);
        if (v > SAT_MAX) return {1'b1, DW'(SAT_MAX)};
        if (v < SAT_MIN) return {1'b1, DW'(SAT_MIN)};
        return {1'b0, v[DW-1:0]};
    endfunction

    always_comb begin
        xr = SW'(a2_re_q) + SW'(t_re);
        xi = SW'(a2_im_q) + SW'(t_im);
        yr = SW'(a2_re_q) - SW'(t_re);
        yi = SW'(a2_im_q) - SW'(t_im);
        if (s2_q) begin
            xr = xr >>> 1;
            xi = xi >>> 1;
            yr = yr >>> 1;
            yi = yi >>> 1;
        end
        sxr     = sat_fn(xr);
        sxi     = sat_fn(xi);
        syr     = sat_fn(yr);
        syi     = sat_fn(yi);
        sat_any = sxr[DW] | sxi[DW] | syr[DW] | syi[DW];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            a1_re_q <= '0;
            a1_im_q <= '0;
            a2_re_q <= '0;
            a2_im_q <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            x_re_q  <= '0;
            x_im_q  <= '0;
            y_re_q  <= '0;
            y_im_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (ld1) begin
                v1_q    <= in_valid;
                a1_re_q <= a_re;
                a1_im_q <= a_im;
                s1_q    <= scale;
            end
            if (ld2) begin
                v2_q    <= v1_q;
                a2_re_q <= a1_re_q;
                a2_im_q <= a1_im_q;
                s2_q    <= s1_q;
            end
            if (ld3) begin
                v3_q   <= v2_q;
                x_re_q <= sxr[DW-1:0];
                x_im_q <= sxi[DW-1:0];
                y_re_q <= syr[DW-1:0];
                y_im_q <= syi[DW-1:0];
            end
            // Bubbles carry stale data, so only real loads may flag overflow.
            if (clr) begin
                ovf_q <= 1'b0;
            end else if (ld3 && v2_q && sat_any) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign out_valid = v3_q;
    assign x_re      = x_re_q;
    assign x_im      = x_im_q;
    assign y_re      = y_re_q;
    assign y_im      = y_im_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_butterfly_pipe.sv
// Directed-vector and scoreboard bench for butterfly_pipe.
module tb_butterfly_pipe;
    import fft_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, scale, ovf, clr;
    logic [15:0] a_re, a_im, b_re, b_im, w_re, w_im;
    logic [15:0] x_re, x_im, y_re, y_im;

    always #5 clk = ~clk;

    butterfly_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_re      (a_re),
        .a_im      (a_im),
        .b_re      (b_re),
        .b_im      (b_im),
        .w_re      (w_re),
        .w_im      (w_im),
        .scale     (scale),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_re      (x_re),
        .x_im      (x_im),
        .y_re      (y_re),
        .y_im      (y_im),
        .ovf       (ovf),
        .clr       (clr)
    );

    typedef struct {
        cplx_t a, b, w;
        logic  sc;
        cplx_t x, y;
        logic  ov;
    } vec_t;

    typedef struct packed {
        logic [15:0] xr, xi, yr, yi;
    } res_t;

    int   n_vec = 0;
    int   n_bad = 0;
    int   n_out = 0;
    bit   sb_on = 1'b0;
    res_t q[$];
    vec_t vt[10];
    vec_t bp[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_res(input string nm, input res_t e);
        chk({nm, ".x_re"}, 32'(x_re), 32'(e.xr));
        chk({nm, ".x_im"}, 32'(x_im), 32'(e.xi));
        chk({nm, ".y_re"}, 32'(y_re), 32'(e.yr));
        chk({nm, ".y_im"}, 32'(y_im), 32'(e.yi));
    endtask

    function automatic vec_t mk(input logic [15:0] ar, ai, br, bi, wr, wi, input logic sc,
                                input logic [15:0] xr, xi, yr, yi, input logic ov);
        vec_t v;
        v.a  = '{re: ar, im: ai};
        v.b  = '{re: br, im: bi};
        v.w  = '{re: wr, im: wi};
        v.sc = sc;
        v.x  = '{re: xr, im: xi};
        v.y  = '{re: yr, im: yi};
        v.ov = ov;
        return v;
    endfunction

    // Independent reference: wide integer arithmetic, wrap t to 18 bits, then saturate.
    function automatic res_t model(input logic [15:0] ar, ai, br, bi, wr, wi, input logic sc);
        longint tr, ti;
        longint v[4];
        logic signed [17:0] t18r, t18i;
        logic [15:0] o[4];
        res_t r;
        tr = longint'($signed(br)) * longint'($signed(wr))
           - longint'($signed(bi)) * longint'($signed(wi));
        ti = longint'($signed(br)) * longint'($signed(wi))
           + longint'($signed(bi)) * longint'($signed(wr));
        tr = (tr + 64'sd8192) >>> 14;
        ti = (ti + 64'sd8192) >>> 14;
        t18r = tr[17:0];
        t18i = ti[17:0];
        v[0] = longint'($signed(ar)) + longint'(t18r);
        v[1] = longint'($signed(ai)) + longint'(t18i);
        v[2] = longint'($signed(ar)) - longint'(t18r);
        v[3] = longint'($signed(ai)) - longint'(t18i);
        for (int k = 0; k < 4; k++) begin
            if (sc) v[k] = v[k] >>> 1;
            if (v[k] > 64'sd32767)       o[k] = 16'h7FFF;
            else if (v[k] < -64'sd32768) o[k] = 16'h8000;
            else                         o[k] = v[k][15:0];
        end
        r.xr = o[0];
        r.xi = o[1];
        r.yr = o[2];
        r.yi = o[3];
        return r;
    endfunction

    task automatic put(input vec_t v);
        a_re  = v.a.re;
        a_im  = v.a.im;
        b_re  = v.b.re;
        b_im  = v.b.im;
        w_re  = v.w.re;
        w_im  = v.w.im;
        scale = v.sc;
    endtask

    // Single transfer on an idle pipe; checks latency, results and ovf.
    task automatic run_vec(input vec_t v, input string nm);
        res_t e;
        e = '{xr: v.x.re, xi: v.x.im, yr: v.y.re, yi: v.y.im};
        put(v);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk({nm, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk({nm, ".early"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk({nm, ".out_valid"}, 32'(out_valid), 32'd1);
        chk_res(nm, e);
        chk({nm, ".ovf"}, 32'(ovf), 32'(v.ov));
    endtask

    // Scoreboard: models every accepted set and checks every delivered result in order.
    always @(posedge clk) begin
        if (sb_on && rst_n) begin
            if (in_valid && in_ready)
                q.push_back(model(a_re, a_im, b_re, b_im, w_re, w_im, scale));
            if (out_valid && out_ready) begin
                n_out++;
                if (q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL sb_extra: got unexpected output %h %h, required none",
                             x_re, x_im);
                end else begin
                    chk_res($sformatf("sb%0d", n_out), q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int idx;
        vec_t v;
        res_t e0;

        vt[0] = mk(16'h1000, 16'h0000, 16'h0800, 16'h0400, ONE, 16'h0000, 1'b0,
                   16'h1800, 16'h0400, 16'h0800, 16'hFC00, 1'b0);
        vt[1] = mk(16'h0000, 16'h0000, 16'h2000, 16'h0000, 16'h0000, NEG_ONE, 1'b0,
                   16'h0000, 16'hE000, 16'h0000, 16'h2000, 1'b0);
        vt[2] = mk(16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h2000, 16'h0000, 1'b0,
                   16'h0001, 16'h0000, 16'hFFFF, 16'h0000, 1'b0);
        vt[3] = mk(16'h0100, 16'h0200, 16'hFFFF, 16'h0000, 16'h2000, 16'h0000, 1'b0,
                   16'h0100, 16'h0200, 16'h0100, 16'h0200, 1'b0);
        vt[4] = mk(16'h1000, 16'h2000, 16'h0800, 16'h0000, ONE, 16'h0000, 1'b1,
                   16'h0C00, 16'h1000, 16'h0400, 16'h1000, 1'b0);
        vt[5] = mk(16'hFFFF, 16'h0003, 16'h0000, 16'h0000, ONE, 16'h0000, 1'b1,
                   16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001, 1'b0);
        vt[6] = mk(16'h0000, 16'h0000, 16'h1000, 16'h0800, 16'h0000, ONE, 1'b0,
                   16'hF800, 16'h1000, 16'h0800, 16'hF000, 1'b0);
        vt[7] = mk(MAX, MIN, MAX, MIN, ONE, 16'h0000, 1'b0,
                   MAX, MIN, 16'h0000, 16'h0000, 1'b1);
        vt[8] = mk(MAX, MIN, MAX, MIN, ONE, 16'h0000, 1'b1,
                   MAX, MIN, 16'h0000, 16'h0000, 1'b1);
        vt[9] = mk(MIN, 16'h0000, MAX, 16'h0000, ONE, 16'h0000, 1'b0,
                   16'hFFFF, 16'h0000, MIN, 16'h0000, 1'b1);

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0;
        put(vt[0]);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.ovf", 32'(ovf), 32'd0);
        chk("rst.x_re", 32'(x_re), 32'd0);
        chk("rst.y_im", 32'(y_im), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // clr alone, then clr on the very edge a saturating result loads.
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("clr.ovf", 32'(ovf), 32'd0);
        put(vt[7]);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("clrsat.out_valid", 32'(out_valid), 32'd1);
        chk("clrsat.ovf", 32'(ovf), 32'd0);
        @(posedge clk); #1;

        // Backpressure: 5 offered back-to-back against a stalled consumer.
        for (int k = 0; k < 5; k++)
            bp[k] = mk(16'($urandom), 16'($urandom), 16'($urandom_range(0, 16'h3FFF)),
                       16'($urandom_range(0, 16'h3FFF)), ONE, 16'h2000, 1'(k & 1),
                       16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
        e0 = model(bp[0].a.re, bp[0].a.im, bp[0].b.re, bp[0].b.im, bp[0].w.re, bp[0].w.im,
                   bp[0].sc);
        n_out = 0;
        sb_on = 1'b1;
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            put(bp[idx]);
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) idx++;
            @(posedge clk); #1;
        end
        chk("bp.accepted", 32'(idx), 32'd3);
        chk("bp.in_ready", 32'(in_ready), 32'd0);
        chk("bp.out_valid", 32'(out_valid), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk_res($sformatf("bp.stall%0d", c), e0);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 5; c++) begin
            put(bp[idx]);
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) idx++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int c = 0; c < 20 && (q.size() != 0 || out_valid); c++) begin
            @(posedge clk); #1;
        end
        chk("bp.pending", 32'(q.size()), 32'd0);
        chk("bp.count", 32'(n_out), 32'd5);

        // Streaming with random gaps on both sides.
        n_out = 0;
        idx = 0;
        for (int c = 0; c < 2000 && idx < 32; c++) begin
            v = mk(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                   16'($urandom), 16'($urandom), 1'($urandom), 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
            put(v);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && (q.size() != 0 || out_valid); c++) begin
            @(posedge clk); #1;
        end
        chk("stream.sent", 32'(idx), 32'd32);
        chk("stream.pending", 32'(q.size()), 32'd0);
        chk("stream.count", 32'(n_out), 32'd32);
        sb_on = 1'b0;

        // Reset with two sets in flight.
        run_vec(vt[7], "pre_rst");
        put(vt[0]);
        in_valid = 1'b1;
        @(posedge clk); #1;
        put(vt[1]);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        chk("inflight.out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst.out_valid", 32'(out_valid), 32'd0);
        chk("arst.ovf", 32'(ovf), 32'd0);
        chk("arst.in_ready", 32'(in_ready), 32'd1);
        chk("arst.x_re", 32'(x_re), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk($sformatf("stale%0d", c), 32'(out_valid), 32'd0);
        end
        run_vec(vt[2], "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
